// File: rtl/dp_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dp_cmd_sequencer_if
//  Purpose  : Bundles the command handshake and every datapath control
//             output of dp_cmd_sequencer.
//  Ports    : cmd/cmd_valid/cmd_ready  - command handshake
//             in_select_a/b            - operand mux selects
//             aluin_reg_en, opcode     - operand bank enable, ALU operation
//             nvalid_data              - low only while the ALU executes
//             memRead, memWrite        - memory strobes
//             selmux2, aluout_reg_en   - result mux select, result bank enable
//             p_error, done            - per-command completion pulses
//             busy, level              - activity flag, FIFO occupancy
//  Modports : master - command source / datapath side
//             slave  - the sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface dp_cmd_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int CW    = 7
);
    logic [CW-1:0]            cmd;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               in_select_a;
    logic [1:0]               in_select_b;
    logic                     aluin_reg_en;
    logic [2:0]               opcode;
    logic                     nvalid_data;
    logic                     memRead;
    logic                     memWrite;
    logic                     selmux2;
    logic                     aluout_reg_en;
    logic                     p_error;
    logic                     done;
    logic                     busy;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output cmd, cmd_valid,
        input  cmd_ready, in_select_a, in_select_b, aluin_reg_en, opcode,
               nvalid_data, memRead, memWrite, selmux2, aluout_reg_en,
               p_error, done, busy, level
    );

    modport slave (
        input  cmd, cmd_valid,
        output cmd_ready, in_select_a, in_select_b, aluin_reg_en, opcode,
               nvalid_data, memRead, memWrite, selmux2, aluout_reg_en,
               p_error, done, busy, level
    );
endinterface
`default_nettype wire

// File: rtl/dp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dp_cmd_sequencer
//  Purpose  : Queues 7-bit datapath commands in a circular FIFO and plays
//             each one out as a fixed multi-cycle sequence of datapath
//             enables/selects. Commands run back-to-back while queued.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous, active-low reset
//             bus  - dp_cmd_sequencer_if.slave (handshake + datapath controls)
//  Command  : [6:4] op (0-5 ALU, 6 MEM_RD, 7 MEM_WR), [3:2] sel_a, [1:0] sel_b
//  Revision : 1.0  initial release
// ============================================================================
module dp_cmd_sequencer #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int CW    = 7
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dp_cmd_sequencer_if.slave  bus
);
    localparam int         c_PTR_W     = $clog2(DEPTH);
    localparam int         c_LVL_W     = $clog2(DEPTH) + 1;
    localparam logic [2:0] c_OP_MEM_RD = 3'd6;
    localparam logic [2:0] c_OP_MEM_WR = 3'd7;
    localparam logic [1:0] c_SEL_BAD   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [CW-1:0]        r_cmd;

    logic                 w_full;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [CW-1:0]        w_head;
    logic                 w_head_illegal;
    logic [2:0]           w_op;
    logic                 w_op_is_alu;

    logic [1:0]           w_sel_a;
    logic [1:0]           w_sel_b;
    logic                 w_aluin_en;
    logic [2:0]           w_opcode;
    logic                 w_nvalid;
    logic                 w_mem_rd;
    logic                 w_mem_wr;
    logic                 w_selmux2;
    logic                 w_aluout_en;
    logic                 w_perr;
    logic                 w_done;

    assign w_full  = (r_level == c_LVL_W'(DEPTH));
    assign w_ready = !w_full && rst;
    assign w_push  = bus.cmd_valid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    // sel_a is used by every command; sel_b only matters for ALU ops.
    assign w_head_illegal = (w_head[3:2] == c_SEL_BAD) ||
                            ((w_head[6:4] < c_OP_MEM_RD) && (w_head[1:0] == c_SEL_BAD));

    assign w_op        = r_cmd[6:4];
    assign w_op_is_alu = (w_op < c_OP_MEM_RD);

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cmd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_cmd    <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_sel_a     = 2'd0;
        w_sel_b     = 2'd0;
        w_aluin_en  = 1'b0;
        w_opcode    = 3'd0;
        w_nvalid    = 1'b1;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_selmux2   = 1'b0;
        w_aluout_en = 1'b0;
        w_perr      = 1'b0;
        w_done      = 1'b0;

        // Terminal states (WB, MEM_WR's MEM, ERR) chain straight into the
        // next queued command so there is no idle bubble between commands.
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head_illegal ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                w_sel_a     = r_cmd[3:2];
                w_sel_b     = r_cmd[1:0];
                w_aluin_en  = 1'b1;
                w_state_nxt = w_op_is_alu ? S_EXEC : S_MEM;
            end
            S_EXEC: begin
                w_nvalid    = 1'b0;
                w_opcode    = w_op;
                w_state_nxt = S_WB;
            end
            S_MEM: begin
                if (w_op == c_OP_MEM_WR) begin
                    w_mem_wr = 1'b1;
                    w_done   = 1'b1;
                    if (r_level != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = w_head_illegal ? S_ERR : S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_mem_rd    = 1'b1;
                    w_state_nxt = S_WB;
                end
            end
            S_WB, S_ERR: begin
                if (r_state == S_WB) begin
                    w_aluout_en = 1'b1;
                    w_selmux2   = (w_op == c_OP_MEM_RD);
                    w_mem_rd    = (w_op == c_OP_MEM_RD);
                    w_done      = 1'b1;
                end else begin
                    w_perr      = 1'b1;
                end
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_head_illegal ? S_ERR : S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = w_ready;
    assign bus.in_select_a   = w_sel_a;
    assign bus.in_select_b   = w_sel_b;
    assign bus.aluin_reg_en  = w_aluin_en;
    assign bus.opcode        = w_opcode;
    assign bus.nvalid_data   = w_nvalid;
    assign bus.memRead       = w_mem_rd;
    assign bus.memWrite      = w_mem_wr;
    assign bus.selmux2       = w_selmux2;
    assign bus.aluout_reg_en = w_aluout_en;
    assign bus.p_error       = w_perr;
    assign bus.done          = w_done;
    assign bus.busy          = (r_state != S_IDLE) || (r_level != '0);
    assign bus.level         = r_level;
endmodule
`default_nettype wire

// File: tb/tb_dp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_cmd_sequencer
//  Purpose  : Directed, self-checking bench for dp_cmd_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = 7;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    logic both_seen;
    logic [3:0] load_q [$];
    logic [2:0] op_q   [$];

    dp_cmd_sequencer_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    dp_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flattened control outputs: {sa, sb, aluin, opcode, nvalid, memRead,
    // memWrite, selmux2, aluout, p_error, done}
    logic [14:0] obs;
    assign obs = {bus.in_select_a, bus.in_select_b, bus.aluin_reg_en, bus.opcode,
                  bus.nvalid_data, bus.memRead, bus.memWrite, bus.selmux2,
                  bus.aluout_reg_en, bus.p_error, bus.done};

    function automatic logic [14:0] ev(input logic [1:0] sa, input logic [1:0] sb,
                                       input logic ain, input logic [2:0] opc,
                                       input logic nv, input logic mr, input logic mw,
                                       input logic s2, input logic aout,
                                       input logic perr, input logic dn);
        return {sa, sb, ain, opc, nv, mr, mw, s2, aout, perr, dn};
    endfunction

    logic [14:0] idle_v;

    // Records what the cycle just ending showed, before the state advances.
    always @(posedge clk) begin
        if (bus.aluin_reg_en) load_q.push_back({bus.in_select_a, bus.in_select_b});
        if (!bus.nvalid_data) op_q.push_back(bus.opcode);
        if (bus.done) done_cnt++;
        if (bus.done && bus.p_error) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [CW-1:0] seq [7];
    int            exp_lvl [9];
    logic [3:0]    exp_sel [7];
    logic [2:0]    exp_op  [7];

    initial begin
        int   idx;
        logic rdy_prev;
        int   d0;

        n_checks = 0; n_errors = 0; done_cnt = 0; both_seen = 1'b0;
        idle_v = ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0; bus.cmd = '0; bus.cmd_valid = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_outputs", obs, idle_v);
        chk("rst_level", bus.level, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready_low", bus.cmd_ready, 0);
        rst = 1'b1;
        #1 chk("rst_release_ready", bus.cmd_ready, 1);

        // ---- single ALU command 0x12 ----
        bus.cmd = 7'h12; bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
        chk("t1_idle", obs, idle_v);
        chk("t1_level1", bus.level, 1);
        chk("t1_busy", bus.busy, 1);
        step(); chk("t1_load", obs, ev(0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("t1_level0", bus.level, 0);
        step(); chk("t1_exec", obs, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("t1_wb", obs, ev(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        step(); chk("t1_after", obs, idle_v);
        chk("t1_busy_fall", bus.busy, 0);

        // ---- MEM_RD 0x64 then MEM_WR 0x70 back-to-back ----
        bus.cmd = 7'h64; bus.cmd_valid = 1'b1; step();
        chk("t2_idle", obs, idle_v);
        bus.cmd = 7'h70; step(); bus.cmd_valid = 1'b0;
        chk("t2_rd_load", obs, ev(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("t2_level_pushpop", bus.level, 1);
        step(); chk("t2_rd_mem", obs, ev(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        step(); chk("t2_rd_wb", obs, ev(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1));
        step(); chk("t2_wr_load", obs, ev(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        chk("t2_wr_level", bus.level, 0);
        step(); chk("t2_wr_mem", obs, ev(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        step(); chk("t2_idle_end", obs, idle_v);
        chk("t2_busy", bus.busy, 0);

        // ---- illegal 0x0F then ALU 0x05 ----
        d0 = done_cnt;
        bus.cmd = 7'h0F; bus.cmd_valid = 1'b1; step();
        bus.cmd = 7'h05; step(); bus.cmd_valid = 1'b0;
        chk("t3_err", obs, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        step(); chk("t3_load", obs, ev(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        step(); chk("t3_exec", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("t3_wb", obs, ev(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        step(); chk("t3_idle", obs, idle_v);
        chk("t3_one_done", done_cnt - d0, 1);

        // ---- MEM_RD with sel_b = 3 is legal; MEM_WR with sel_a = 3 is not ----
        bus.cmd = 7'h67; bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
        step(); chk("t3b_memrd_selb3_load", obs, ev(1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        step(); step(); step();
        chk("t3b_idle", bus.busy, 0);
        bus.cmd = 7'h7C; bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
        step(); chk("t3c_memwr_sela3_err", obs, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        step(); chk("t3c_idle", obs, idle_v);

        // ---- DEPTH+3 commands with cmd_valid held high ----
        seq     = '{7'h11, 7'h24, 7'h35, 7'h48, 7'h52, 7'h09, 7'h1A};
        exp_sel = '{4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b0010, 4'b1001, 4'b1010};
        exp_op  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        exp_lvl = '{1, 1, 2, 3, 3, 4, 4, 3, 4};
        load_q.delete(); op_q.delete();
        idx = 0; rdy_prev = 1'b1;
        for (int e = 0; e < 9; e++) begin
            bus.cmd = seq[idx]; bus.cmd_valid = 1'b1;
            step();
            if (rdy_prev) idx++;
            chk($sformatf("t4_level_e%0d", e), bus.level, exp_lvl[e]);
            rdy_prev = (exp_lvl[e] != DEPTH);
            chk($sformatf("t4_ready_e%0d", e), bus.cmd_ready, rdy_prev);
        end
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 40 && bus.busy; k++) step();
        chk("t4_drain", bus.busy, 0);
        chk("t4_count", load_q.size(), 7);
        chk("t4_op_count", op_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < load_q.size()) chk($sformatf("t4_order_%0d", i), load_q[i], exp_sel[i]);
            if (i < op_q.size())   chk($sformatf("t4_op_%0d", i), op_q[i], exp_op[i]);
        end

        // ---- reset during EXEC with 2 commands queued ----
        bus.cmd = 7'h12; bus.cmd_valid = 1'b1; step();
        bus.cmd = 7'h24; step();
        bus.cmd = 7'h35; step(); bus.cmd_valid = 1'b0;
        chk("t6_exec", obs, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("t6_queued", bus.level, 2);
        d0 = done_cnt;
        rst = 1'b0;
        #1 chk("t6_ready_in_rst", bus.cmd_ready, 0);
        step();
        chk("t6_rst_outputs", obs, idle_v);
        chk("t6_rst_level", bus.level, 0);
        chk("t6_rst_busy", bus.busy, 0);
        rst = 1'b1; step();
        chk("t6_post_idle", obs, idle_v);
        chk("t6_post_busy", bus.busy, 0);
        chk("t6_no_done", done_cnt - d0, 0);
        bus.cmd = 7'h48; bus.cmd_valid = 1'b1; step(); bus.cmd_valid = 1'b0;
        chk("t6_accept", bus.level, 1);
        step(); chk("t6_load", obs, ev(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        step(); chk("t6_exec2", obs, ev(0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
        step(); chk("t6_wb", obs, ev(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        step(); chk("t6_idle", bus.busy, 0);

        chk("done_perr_exclusive", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
